game_sequencer: RTL and testbench

//   Game-level controller: sequences the player/obstacle datapath through IDLE, RUN, HIT and OVER.

---
 rtl/game_sequencer.sv | 166 ++++++++++++++++
 tb/tb_game_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Game-level controller: IDLE/RUN/HIT/OVER sequencing, obstacle tick gating,
// per-frame player/obstacle collision detection, lives and saturating score.
module game_sequencer #(
  parameter int unsigned PLAYER_SIZE = 40,
  parameter int unsigned OBS_W       = 40,
  parameter int unsigned OBS_Y0      = 500,
  parameter int unsigned OBS_Y1      = 580,
  parameter int unsigned LIVES       = 3,
  parameter int unsigned HIT_FRAMES  = 60,
  parameter int unsigned SCORE_DIV   = 60,
  // Score value loaded by reset only; lets a bench start near saturation.
  parameter logic [15:0] SCORE_INIT  = 16'h0000
) (
  input  logic               clk_148Mhz,
  input  logic               reset,
  input  logic               tick_in,
  input  logic               frame_start,
  input  logic               btn_start,
  input  logic signed [11:0] x_pos,
  input  logic signed [11:0] y_pos,
  input  logic        [10:0] x_obs1,
  input  logic        [10:0] x_obs2,
  input  logic        [10:0] x_obs3,
  output logic               tick_obs,
  output logic               freeze,
  output logic               obs_reset,
  output logic        [1:0]  game_state,
  output logic        [1:0]  lives,
  output logic        [15:0] score
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StHit  = 2'd2;
  localparam logic [1:0] StOver = 2'd3;

  localparam int unsigned FrameW = $clog2(SCORE_DIV + 1);
  localparam int unsigned HitW   = $clog2(HIT_FRAMES + 1);

  localparam logic signed [12:0] PlayerSz = 13'(PLAYER_SIZE);
  localparam logic signed [12:0] ObsW     = 13'(OBS_W);
  localparam logic signed [12:0] BandY0   = 13'(OBS_Y0);
  localparam logic signed [12:0] BandY1   = 13'(OBS_Y1);
  localparam logic [1:0]         LivesInit = 2'(LIVES);
  localparam logic [FrameW-1:0]  FrameLast = FrameW'(SCORE_DIV - 1);
  localparam logic [HitW-1:0]    HitLast   = HitW'(HIT_FRAMES - 1);

  logic [1:0]        state_q, state_d;
  logic [1:0]        lives_q, lives_d;
  logic [15:0]       score_q, score_d;
  logic [FrameW-1:0] frame_cnt_q, frame_cnt_d;
  logic [HitW-1:0]   hit_cnt_q, hit_cnt_d;
  logic              tick_obs_q, tick_obs_d;
  logic              freeze_q, freeze_d;
  logic              obs_reset_q, obs_reset_d;

  // Collision detection: all compares done in 13-bit signed space so a player
  // partly off the left edge (negative x_pos) still overlaps correctly.
  logic signed [12:0] px, py;
  logic        [10:0] x_obs [3];
  logic        [2:0]  obs_hit;
  logic               collide;

  assign px = {x_pos[11], x_pos};
  assign py = {y_pos[11], y_pos};
  assign x_obs[0] = x_obs1;
  assign x_obs[1] = x_obs2;
  assign x_obs[2] = x_obs3;

  for (genvar g = 0; g < 3; g++) begin : g_obs
    logic signed [12:0] ox;
    assign ox = {2'b00, x_obs[g]};
    assign obs_hit[g] = (px < ox + ObsW) && (ox < px + PlayerSz) &&
                        (py < BandY1) && (BandY0 < py + PlayerSz);
  end

  // Several overlapping obstacles in one frame still count as a single hit.
  assign collide = |obs_hit;

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    score_d     = score_q;
    frame_cnt_d = frame_cnt_q;
    hit_cnt_d   = hit_cnt_q;

    case (state_q)
      StIdle: begin
        if (btn_start) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (frame_start) begin
          if (collide) begin
            lives_d   = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
            hit_cnt_d = '0;
            state_d   = StHit;
          end else if (frame_cnt_q == FrameLast) begin
            frame_cnt_d = '0;
            if (score_q != 16'hFFFF) begin
              score_d = score_q + 16'd1;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + FrameW'(1);
          end
        end
      end
      StHit: begin
        if (frame_start) begin
          if (hit_cnt_q == HitLast) begin
            state_d = (lives_q == 2'd0) ? StOver : StRun;
          end else begin
            hit_cnt_d = hit_cnt_q + HitW'(1);
          end
        end
      end
      StOver: begin
        if (btn_start) begin
          state_d     = StIdle;
          lives_d     = LivesInit;
          score_d     = '0;
          frame_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // freeze follows the next state so it lines up with game_state.
  always_comb begin
    tick_obs_d  = tick_in && (state_q == StRun);
    freeze_d    = (state_d != StRun);
    obs_reset_d = (state_q == StOver) && btn_start;
  end

  always_ff @(posedge clk_148Mhz or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      lives_q     <= LivesInit;
      score_q     <= SCORE_INIT;
      frame_cnt_q <= '0;
      hit_cnt_q   <= '0;
      tick_obs_q  <= 1'b0;
      freeze_q    <= 1'b1;
      obs_reset_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      frame_cnt_q <= frame_cnt_d;
      hit_cnt_q   <= hit_cnt_d;
      tick_obs_q  <= tick_obs_d;
      freeze_q    <= freeze_d;
      obs_reset_q <= obs_reset_d;
    end
  end

  assign game_state = state_q;
  assign lives      = lives_q;
  assign score      = score_q;
  assign tick_obs   = tick_obs_q;
  assign freeze     = freeze_q;
  assign obs_reset  = obs_reset_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed scenarios plus a randomized phase, all
// checked cycle by cycle against a behavioural game model.
module tb_game_sequencer;

  localparam int PlayerSize = 40;
  localparam int ObsWidth   = 40;
  localparam int BandTop    = 500;
  localparam int BandBot    = 580;
  localparam int LivesInit  = 3;
  localparam int HitFrames  = 60;
  localparam int ScoreDiv   = 4;

  logic clk_148Mhz = 1'b0;
  always #5 clk_148Mhz = ~clk_148Mhz;

  logic               reset;
  logic               tick_in, frame_start, btn_start;
  logic signed [11:0] x_pos, y_pos;
  logic        [10:0] x_obs1, x_obs2, x_obs3;
  logic               tick_obs, freeze, obs_reset;
  logic        [1:0]  game_state, lives;
  logic        [15:0] score;

  logic               s_btn, s_frame;
  logic               s_tick_obs, s_freeze, s_obs_reset;
  logic        [1:0]  s_state, s_lives;
  logic        [15:0] s_score;

  game_sequencer #(.SCORE_DIV(ScoreDiv)) u_dut (
    .clk_148Mhz  (clk_148Mhz),
    .reset       (reset),
    .tick_in     (tick_in),
    .frame_start (frame_start),
    .btn_start   (btn_start),
    .x_pos       (x_pos),
    .y_pos       (y_pos),
    .x_obs1      (x_obs1),
    .x_obs2      (x_obs2),
    .x_obs3      (x_obs3),
    .tick_obs    (tick_obs),
    .freeze      (freeze),
    .obs_reset   (obs_reset),
    .game_state  (game_state),
    .lives       (lives),
    .score       (score)
  );

  // Second instance starts one point below saturation to exercise the ceiling.
  game_sequencer #(.SCORE_DIV(1), .SCORE_INIT(16'hFFFE)) u_sat (
    .clk_148Mhz  (clk_148Mhz),
    .reset       (reset),
    .tick_in     (1'b0),
    .frame_start (s_frame),
    .btn_start   (s_btn),
    .x_pos       (12'sd0),
    .y_pos       (12'sd0),
    .x_obs1      (11'd0),
    .x_obs2      (11'd0),
    .x_obs3      (11'd0),
    .tick_obs    (s_tick_obs),
    .freeze      (s_freeze),
    .obs_reset   (s_obs_reset),
    .game_state  (s_state),
    .lives       (s_lives),
    .score       (s_score)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: 0 idle, 1 playing, 2 hit pause, 3 game over.
  int m_state, m_lives, m_score, m_frames, m_hit_frames;
  int m_tick, m_freeze, m_obs_reset;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_lives = LivesInit; m_score = 0; m_frames = 0; m_hit_frames = 0;
    m_tick = 0; m_freeze = 1; m_obs_reset = 0;
  endtask

  function automatic bit player_hits();
    int xp, yp;
    int xo[3];
    xp = int'(x_pos);
    yp = int'(y_pos);
    xo[0] = int'(x_obs1);
    xo[1] = int'(x_obs2);
    xo[2] = int'(x_obs3);
    for (int i = 0; i < 3; i++) begin
      if (xp < xo[i] + ObsWidth && xo[i] < xp + PlayerSize &&
          yp < BandBot && BandTop < yp + PlayerSize) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_step();
    int nxt;
    nxt = m_state;
    m_tick = (tick_in && m_state == 1) ? 1 : 0;
    m_obs_reset = (btn_start && m_state == 3) ? 1 : 0;
    if (m_state == 0 && btn_start) begin
      nxt = 1;
    end else if (m_state == 1 && frame_start) begin
      if (player_hits()) begin
        if (m_lives > 0) m_lives--;
        m_hit_frames = 0;
        nxt = 2;
      end else begin
        m_frames++;
        if (m_frames == ScoreDiv) begin
          m_frames = 0;
          if (m_score < 65535) m_score++;
        end
      end
    end else if (m_state == 2 && frame_start) begin
      m_hit_frames++;
      if (m_hit_frames == HitFrames) nxt = (m_lives == 0) ? 3 : 1;
    end else if (m_state == 3 && btn_start) begin
      nxt = 0; m_lives = LivesInit; m_score = 0; m_frames = 0;
    end
    m_state = nxt;
    m_freeze = (m_state != 1) ? 1 : 0;
  endtask

  task automatic check_all();
    check("game_state", 32'(game_state), m_state);
    check("lives", 32'(lives), m_lives);
    check("score", 32'(score), m_score);
    check("tick_obs", 32'(tick_obs), m_tick);
    check("freeze", 32'(freeze), m_freeze);
    check("obs_reset", 32'(obs_reset), m_obs_reset);
  endtask

  task automatic step();
    @(posedge clk_148Mhz);
    model_step();
    @(negedge clk_148Mhz);
    check_all();
    tick_in = 1'b0; frame_start = 1'b0; btn_start = 1'b0; s_btn = 1'b0; s_frame = 1'b0;
  endtask

  // Frames with tick_in pulsing alongside, so any leak through the gate shows.
  task automatic frames(input int n);
    repeat (n) begin
      frame_start = 1'b1; tick_in = 1'b1;
      step();
      step();
    end
  endtask

  task automatic safe_pos();
    x_pos = 12'sd100; y_pos = 12'sd100;
    x_obs1 = 11'd1500; x_obs2 = 11'd1600; x_obs3 = 11'd1700;
  endtask

  initial begin
    int v;
    reset = 1'b1; tick_in = 1'b0; frame_start = 1'b0; btn_start = 1'b0;
    s_btn = 1'b0; s_frame = 1'b0;
    safe_pos();
    model_reset();
    repeat (3) @(negedge clk_148Mhz);
    check_all();
    check("sat_reset_score", 32'(s_score), 32'hFFFE);
    reset = 1'b0;

    // Saturation on the preloaded instance
    s_btn = 1'b1; step();
    check("sat_state_run", 32'(s_state), 32'd1);
    check("sat_freeze", 32'(s_freeze), 32'd0);
    s_frame = 1'b1; step();
    check("sat_score_max", 32'(s_score), 32'hFFFF);
    s_frame = 1'b1; step();
    check("sat_score_hold", 32'(s_score), 32'hFFFF);
    check("sat_lives", 32'(s_lives), 32'd3);
    check("sat_tick", 32'(s_tick_obs), 32'd0);
    check("sat_obs_reset", 32'(s_obs_reset), 32'd0);

    // T1: idle with free-running tick
    for (int c = 0; c < 1000; c++) begin
      tick_in = (c % 16 == 0);
      step();
    end
    check("t1_state", 32'(game_state), 32'd0);
    check("t1_lives", 32'(lives), 32'd3);
    check("t1_freeze", 32'(freeze), 32'd1);

    // T2: start, tick gating latency
    btn_start = 1'b1; frame_start = 1'b1; step();
    check("t2_state", 32'(game_state), 32'd1);
    check("t2_freeze", 32'(freeze), 32'd0);
    tick_in = 1'b1; step();
    check("t2_tick_hi", 32'(tick_obs), 32'd1);
    step();
    check("t2_tick_lo", 32'(tick_obs), 32'd0);

    // T3: single obstacle hit and recovery
    x_pos = 12'sd100; y_pos = 12'sd480; x_obs1 = 11'd130;
    frame_start = 1'b1; step();
    check("t3_state_hit", 32'(game_state), 32'd2);
    check("t3_lives", 32'(lives), 32'd2);
    safe_pos();
    frames(59);
    check("t3_still_hit", 32'(game_state), 32'd2);
    frames(1);
    check("t3_back_run", 32'(game_state), 32'd1);

    // T4: triple overlap is one hit; touching edge; negative x
    x_obs1 = 11'd100; x_obs2 = 11'd100; x_obs3 = 11'd100;
    x_pos = 12'sd100; y_pos = 12'sd520;
    frame_start = 1'b1; step();
    check("t4_lives_once", 32'(lives), 32'd1);
    safe_pos();
    frames(HitFrames);
    x_pos = 12'sd60; y_pos = 12'sd520; x_obs1 = 11'd100;
    frame_start = 1'b1; step();
    check("t4_touch_state", 32'(game_state), 32'd1);
    check("t4_touch_lives", 32'(lives), 32'd1);
    x_pos = -12'sd20; x_obs1 = 11'd0;
    frame_start = 1'b1; step();
    check("t4_neg_hit", 32'(game_state), 32'd2);
    check("t4_neg_lives", 32'(lives), 32'd0);

    // T5: game over and restart
    safe_pos();
    frames(HitFrames);
    check("t5_over", 32'(game_state), 32'd3);
    btn_start = 1'b1; step();
    check("t5_idle", 32'(game_state), 32'd0);
    check("t5_obs_reset", 32'(obs_reset), 32'd1);
    check("t5_lives", 32'(lives), 32'd3);
    step();
    check("t5_obs_reset_done", 32'(obs_reset), 32'd0);

    // T6: score divider
    btn_start = 1'b1; step();
    repeat (9) begin
      frame_start = 1'b1; step();
    end
    check("t6_score", 32'(score), 32'd2);

    // Randomized play
    for (int c = 0; c < 4000; c++) begin
      tick_in = ($urandom % 4 == 0);
      frame_start = ($urandom % 8 == 0);
      btn_start = ($urandom % 32 == 0);
      if ($urandom % 16 == 0) begin
        v = int'($urandom_range(0, 900)) - 100;
        x_pos = 12'(v);
        y_pos = 12'(int'($urandom_range(400, 620)));
        x_obs1 = 11'($urandom_range(0, 800));
        x_obs2 = 11'($urandom_range(0, 800));
        x_obs3 = 11'($urandom_range(0, 800));
      end
      step();
    end

    // Reset asserted while frozen in HIT
    reset = 1'b1;
    model_reset();
    @(negedge clk_148Mhz);
    reset = 1'b0;
    btn_start = 1'b1; step();
    x_pos = 12'sd100; y_pos = 12'sd520; x_obs1 = 11'd100;
    frame_start = 1'b1; step();
    check("t6_in_hit", 32'(game_state), 32'd2);
    step();
    #2 reset = 1'b1;
    #1;
    check("t6_rst_state", 32'(game_state), 32'd0);
    check("t6_rst_obs_reset", 32'(obs_reset), 32'd0);
    check("t6_rst_lives", 32'(lives), 32'd3);
    model_reset();
    @(negedge clk_148Mhz);
    check_all();
    reset = 1'b0;
    step();
    check("t6_post_obs_reset", 32'(obs_reset), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
